// File: rtl/dbb_arb_pkg.sv
// Shared types and constants for the DBB read-address arbiter.
package dbb_arb_pkg;

    typedef enum logic {
        IDLE,
        ISSUE
    } arb_state_e;

    localparam logic [1:0] DBB_BURST_INCR = 2'b01;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/dbb_rd_arbiter_if.sv
// Client-side and DBB-side read channels of the arbiter, grouped as one bundle.
interface dbb_rd_arbiter_if #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned LEN_WIDTH      = 4,
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned MEM_DATA_WIDTH = 512
);

    logic [NUM_REQ-1:0]            req_arvalid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr;
    logic [NUM_REQ*LEN_WIDTH-1:0]  req_arlen;
    logic [NUM_REQ-1:0]            req_arready;

    logic                          arvalid;
    logic [ADDR_WIDTH-1:0]         araddr;
    logic [LEN_WIDTH-1:0]          arlen;
    logic [2:0]                    arsize;
    logic [1:0]                    arburst;
    logic [ID_WIDTH-1:0]           arid;
    logic                          arready;

    logic                          rvalid;
    logic                          rlast;
    logic [MEM_DATA_WIDTH-1:0]     rdata;
    logic [ID_WIDTH-1:0]           rid;
    logic                          rready;

    logic [NUM_REQ-1:0]            req_rvalid;
    logic [MEM_DATA_WIDTH-1:0]     req_rdata;
    logic                          req_rlast;
    logic [NUM_REQ-1:0]            req_rready;

    logic                          rid_err;

    // Arbiter side
    modport slave (
        input  req_arvalid, req_araddr, req_arlen, arready,
        input  rvalid, rlast, rdata, rid, req_rready,
        output req_arready, arvalid, araddr, arlen, arsize, arburst, arid,
        output rready, req_rvalid, req_rdata, req_rlast, rid_err
    );

    // Environment side (clients plus DBB port)
    modport master (
        output req_arvalid, req_araddr, req_arlen, arready,
        output rvalid, rlast, rdata, rid, req_rready,
        input  req_arready, arvalid, araddr, arlen, arsize, arburst, arid,
        input  rready, req_rvalid, req_rdata, req_rlast, rid_err
    );

endinterface

// File: rtl/dbb_rd_arbiter_rr_pick.sv
// Rotating-priority picker: first eligible client at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               found
);

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned idx;
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!found && elig[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dbb_rd_arbiter.sv
// Round-robin sharing of one DBB AR channel among read clients, with
// per-client outstanding-burst throttling and rid-based R routing.
module dbb_rd_arbiter
    import dbb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned LEN_WIDTH      = 4,
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned MEM_DATA_WIDTH = 512,
    parameter int unsigned MAX_OUTST      = 8
) (
    input logic            clk,
    input logic            rst,
    dbb_rd_arbiter_if.slave bus
);

    localparam int unsigned PTR_W   = clog2(NUM_REQ);
    localparam int unsigned CNT_W   = clog2(MAX_OUTST + 1);
    localparam logic [2:0]  AR_SIZE = 3'(clog2(MEM_DATA_WIDTH / 8));

    arb_state_e              state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]        outst_q [NUM_REQ];
    logic [CNT_W-1:0]        outst_d [NUM_REQ];
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [LEN_WIDTH-1:0]    arlen_q, arlen_d;
    logic [ID_WIDTH-1:0]     arid_q, arid_d;
    logic                    rid_err_q, rid_err_d;

    logic [NUM_REQ-1:0]      elig, gnt, inc, dec, rvalid_route;
    logic                    found;
    logic [PTR_W-1:0]        rid_idx;
    logic                    rid_ok, rready_c, underflow;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            elig[i] = bus.req_arvalid[i] && (outst_q[i] < CNT_W'(MAX_OUTST));
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .elig  (elig),
        .ptr   (ptr_q),
        .gnt   (gnt),
        .found (found)
    );

    // R routing is purely combinational and deliberately ignores reset state.
    always_comb begin
        rid_idx  = bus.rid[PTR_W-1:0];
        rid_ok   = ((bus.rid >> PTR_W) == '0) && (32'(rid_idx) < NUM_REQ);
        rready_c = rid_ok ? bus.req_rready[rid_idx] : 1'b1;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rvalid_route[i] = bus.rvalid && rid_ok && (rid_idx == PTR_W'(i));
            dec[i]          = rvalid_route[i] && rready_c && bus.rlast;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arid_d    = arid_q;
        inc       = '0;
        underflow = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            outst_d[i] = outst_q[i];
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = ISSUE;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (gnt[i]) begin
                            araddr_d = bus.req_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                            arlen_d  = bus.req_arlen[i*LEN_WIDTH +: LEN_WIDTH];
                            arid_d   = ID_WIDTH'(i);
                            ptr_d    = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
                        end
                    end
                end
            end
            ISSUE: begin
                if (bus.arready) begin
                    state_d = IDLE;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        inc[i] = (arid_q == ID_WIDTH'(i));
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Simultaneous issue and completion on one client cancel out.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            case ({inc[i], dec[i]})
                2'b10: outst_d[i] = outst_q[i] + CNT_W'(1);
                2'b01: begin
                    if (outst_q[i] == '0) begin
                        underflow = 1'b1;
                    end else begin
                        outst_d[i] = outst_q[i] - CNT_W'(1);
                    end
                end
                default: outst_d[i] = outst_q[i];
            endcase
        end

        rid_err_d = rid_err_q || (bus.rvalid && !rid_ok) || underflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arid_q    <= '0;
            rid_err_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                outst_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arid_q    <= arid_d;
            rid_err_q <= rid_err_d;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                outst_q[i] <= outst_d[i];
            end
        end
    end

    assign bus.req_arready = (state_q == IDLE) ? gnt : '0;
    assign bus.arvalid     = (state_q == ISSUE);
    assign bus.araddr      = araddr_q;
    assign bus.arlen       = arlen_q;
    assign bus.arid        = arid_q;
    assign bus.arsize      = AR_SIZE;
    assign bus.arburst     = DBB_BURST_INCR;
    assign bus.rready      = rready_c;
    assign bus.req_rvalid  = rvalid_route;
    assign bus.req_rdata   = bus.rdata;
    assign bus.req_rlast   = bus.rlast;
    assign bus.rid_err     = rid_err_q;

endmodule

// File: doc/dbb_rd_arbiter.md
# dbb_rd_arbiter

Round-robin arbiter that shares one DBB read-address channel among `NUM_REQ` internal read clients and routes DBB read-data beats back to the owning client by `rid`. It sits between the engine-side read clients and the DBB master port, and it throttles each client to `MAX_OUTST` outstanding bursts. It is sequential: grant FSM, rotating priority pointer, per-client outstanding counters, and a registered AR stage that holds values stable until `arready`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of read clients, 2..8.
- `ADDR_WIDTH`, 64: DBB address width.
- `LEN_WIDTH`, 4: DBB `arlen` width.
- `ID_WIDTH`, 8: DBB `arid`/`rid` width. Must be ≥ clog2(`NUM_REQ`).
- `MEM_DATA_WIDTH`, 512: read data width.
- `MAX_OUTST`, 8: maximum outstanding bursts per client, 1..15.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `req_arvalid`, in, `NUM_REQ`: client address request.
- `req_araddr`, in, `NUM_REQ*ADDR_WIDTH`: client addresses, packed, client 0 in the LSBs.
- `req_arlen`, in, `NUM_REQ*LEN_WIDTH`: client burst lengths (beats−1).
- `req_arready`, out, `NUM_REQ`: one-hot grant/accept.
- `arvalid`, `araddr`, `arlen`, `arsize`, `arburst`, `arid`, out: DBB AR channel.
- `arready`, in, 1: DBB AR channel.
- `rvalid`, in, 1: DBB R channel.
- `rlast`, in, 1: DBB R channel.
- `rdata`, in, `MEM_DATA_WIDTH`: DBB R channel.
- `rid`, in, `ID_WIDTH`: DBB R channel.
- `rready`, out, 1: DBB R channel.
- `req_rvalid`, out, `NUM_REQ`: one-hot data-valid per client.
- `req_rdata`, out, `MEM_DATA_WIDTH`: shared data bus (= `rdata`).
- `req_rlast`, out, 1: shared last flag (= `rlast`).
- `req_rready`, in, `NUM_REQ`: per-client data ready.
- `rid_err`, out, 1: sticky flag, set by an out-of-range `rid`.

## Operation
FSM states:
- IDLE:
  - Eligible clients: `req_arvalid[i]` && `outst[i] < MAX_OUTST`.
  - Select the first eligible client at or after `ptr`, wrapping modulo `NUM_REQ`.
  - If one is found: `req_arready[i]=1` combinationally in the same cycle, capture its addr/len into the AR register, set `arid=i` (zero-extended), set `ptr=(i+1)%NUM_REQ`, go to ISSUE.
- ISSUE:
  - `arvalid=1`; AR register held constant.
  - On `arready`: `outst[arid]++`, go to IDLE.
  - No grants are made while in ISSUE.

Fixed AR fields:
- `arsize` = clog2(`MEM_DATA_WIDTH/8`) (6 at the default width).
- `arburst` = 2'b01 (INCR).

R routing, combinational:
- If `rid < NUM_REQ`: `req_rvalid[rid]=rvalid` and `rready=req_rready[rid]`.
- If `rid >= NUM_REQ`: `rready=1`, the beat is dropped, no `req_rvalid`, and `rid_err` is set while `rvalid`.
- Beat completion is `rvalid && rready && rlast` with an in-range `rid`; it decrements `outst[rid]`.

Counter rules:
- Counter width is clog2(`MAX_OUTST+1`).
- Increment and decrement of the same counter in the same cycle leave it unchanged.
- A decrement at 0 never occurs for well-formed traffic; the counter saturates at 0 and sets `rid_err`.

Reset (any cycle, including mid-burst):
- FSM to IDLE, `ptr=0`, all `outst=0`.
- `arvalid=0`; `araddr`, `arlen`, `arid` = 0; `rid_err=0`.
- In-flight bursts are forgotten.
- `rready` and `req_rvalid` follow the combinational routing rule, with no gating from reset state.

## Timing
- Grant to `arvalid`: `req_arready` in cycle N, `arvalid` rises in N+1.
- Minimum AR spacing is 2 cycles, giving peak AR throughput of 1 per 2 cycles.
- `arvalid` never drops, and AR fields never change, until `arready` is seen.
- R path has zero latency: `rvalid` → `req_rvalid` and `req_rready` → `rready` in the same cycle.
- A client that reaches `MAX_OUTST` becomes ineligible from the cycle after its final AR handshake.
- It becomes eligible again in the cycle after its completing `rlast`.

## Structure
- Package `dbb_arb_pkg`:
  - FSM state enum {IDLE, ISSUE}.
  - `DBB_BURST_INCR` = 2'b01.
  - clog2 helper function.
- One sub-module, `rr_pick`: combinational rotating-priority picker, inputs `elig[NUM_REQ]` and `ptr`, outputs one-hot `gnt` and `found`.
- Counters and FSM live in the top module.

## Test plan
- Single request: client 2 requests addr 0x1000, len 3, `arready` tied 1 → `req_arready[2]` in cycle 0; `arvalid` with `araddr=0x1000`, `arlen=3`, `arid=2`, `arsize=6`, `arburst=1` in cycle 1; `outst[2]=1`.
- Fairness: all 4 clients request continuously, `arready=1` → `arid` sequence 0,1,2,3,0,… with one AR every 2 cycles.
- Backpressure: `arready=0` for 5 cycles during ISSUE → `arvalid` and fields stable for all 5 cycles; no new `req_arready`; handshake lands on the 6th cycle.
- Throttle: `MAX_OUTST=2`, client 1 issues 2 bursts with no R returned → its 3rd request is not granted while other clients are; after one `rlast` with `rid=1`, client 1 is granted on the next IDLE cycle.
- R routing: `rvalid` with `rid=3` and `req_rready[3]=0` → `req_rvalid=4'b1000`, `rready=0`; then `rid=9` → `rready=1`, `rid_err=1` and it stays set.
- Reset mid-ISSUE with `outst=[1,2,0,1]` → next cycle `arvalid=0`, all counters 0, `ptr=0`, `rid_err=0`.
